// File: rtl/prefix_sched.sv
// Two-requester round-robin front end for a prefix engine: streams a fixed
// 19-token burst from the granted requester, then waits for the engine result.
module prefix_sched (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_a,
    input  logic               req_b,
    output logic               gnt_a,
    output logic               gnt_b,
    input  logic               opt_a,
    input  logic               opt_b,
    input  logic [4:0]         tok_a,
    input  logic [4:0]         tok_b,
    output logic               eng_in_valid,
    output logic               eng_opt,
    output logic [4:0]         eng_in_data,
    input  logic               eng_out_valid,
    input  logic signed [94:0] eng_out,
    output logic               res_valid,
    output logic               res_id,
    output logic               res_err,
    output logic signed [94:0] res_data
);

    localparam int unsigned TOK_W   = 5;
    localparam int unsigned DATA_W  = 95;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned TO_W    = 7;
    localparam int unsigned NUM_TOK = 19;
    localparam int unsigned TIMEOUT = 64;

    localparam logic [CNT_W-1:0] LAST_TOK = CNT_W'(NUM_TOK - 1);
    localparam logic [TO_W-1:0]  LAST_TO  = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [TO_W-1:0]           to_q, to_d;
    logic                      owner_q, owner_d;
    logic                      prio_q, prio_d;
    logic                      gnt_a_q, gnt_a_d;
    logic                      gnt_b_q, gnt_b_d;
    logic                      eng_in_valid_q, eng_in_valid_d;
    logic                      eng_opt_q, eng_opt_d;
    logic [TOK_W-1:0]          eng_in_data_q, eng_in_data_d;
    logic                      res_valid_q, res_valid_d;
    logic                      res_id_q, res_id_d;
    logic                      res_err_q, res_err_d;
    logic signed [DATA_W-1:0]  res_data_q, res_data_d;

    logic                      pick_b;
    logic [TOK_W-1:0]          sel_tok;
    logic                      sel_opt;

    // B wins only when A is idle or B holds the round-robin priority
    assign pick_b  = req_b & (~req_a | prio_q);
    assign sel_tok = owner_q ? tok_b : tok_a;
    assign sel_opt = owner_q ? opt_b : opt_a;

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        to_d           = to_q;
        owner_d        = owner_q;
        prio_d         = prio_q;
        gnt_a_d        = gnt_a_q;
        gnt_b_d        = gnt_b_q;
        eng_in_valid_d = 1'b0;
        eng_opt_d      = 1'b0;
        eng_in_data_d  = '0;
        res_valid_d    = 1'b0;
        res_id_d       = 1'b0;
        res_err_d      = 1'b0;
        res_data_d     = '0;

        case (state_q)
            IDLE: begin
                if (req_a | req_b) begin
                    state_d = STREAM;
                    owner_d = pick_b;
                    gnt_a_d = ~pick_b;
                    gnt_b_d = pick_b;
                    cnt_d   = '0;
                end
            end
            STREAM: begin
                eng_in_valid_d = 1'b1;
                eng_in_data_d  = sel_tok;
                eng_opt_d      = (cnt_q == '0) ? sel_opt : eng_opt_q;
                if (cnt_q == LAST_TOK) begin
                    state_d = WAIT;
                    gnt_a_d = 1'b0;
                    gnt_b_d = 1'b0;
                    cnt_d   = '0;
                    to_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT: begin
                // A result arriving on the timeout cycle still wins
                if (eng_out_valid) begin
                    state_d     = RESP;
                    res_valid_d = 1'b1;
                    res_id_d    = owner_q;
                    res_data_d  = eng_out;
                    prio_d      = ~owner_q;
                end else if (to_q == LAST_TO) begin
                    state_d     = RESP;
                    res_valid_d = 1'b1;
                    res_id_d    = owner_q;
                    res_err_d   = 1'b1;
                    prio_d      = ~owner_q;
                    to_d        = to_q + TO_W'(1);
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                to_d    = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            to_q           <= '0;
            owner_q        <= 1'b0;
            prio_q         <= 1'b0;
            gnt_a_q        <= 1'b0;
            gnt_b_q        <= 1'b0;
            eng_in_valid_q <= 1'b0;
            eng_opt_q      <= 1'b0;
            eng_in_data_q  <= '0;
            res_valid_q    <= 1'b0;
            res_id_q       <= 1'b0;
            res_err_q      <= 1'b0;
            res_data_q     <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            to_q           <= to_d;
            owner_q        <= owner_d;
            prio_q         <= prio_d;
            gnt_a_q        <= gnt_a_d;
            gnt_b_q        <= gnt_b_d;
            eng_in_valid_q <= eng_in_valid_d;
            eng_opt_q      <= eng_opt_d;
            eng_in_data_q  <= eng_in_data_d;
            res_valid_q    <= res_valid_d;
            res_id_q       <= res_id_d;
            res_err_q      <= res_err_d;
            res_data_q     <= res_data_d;
        end
    end

    assign gnt_a        = gnt_a_q;
    assign gnt_b        = gnt_b_q;
    assign eng_in_valid = eng_in_valid_q;
    assign eng_opt      = eng_opt_q;
    assign eng_in_data  = eng_in_data_q;
    assign res_valid    = res_valid_q;
    assign res_id       = res_id_q;
    assign res_err      = res_err_q;
    assign res_data     = res_data_q;

endmodule

// File: tb/tb_prefix_sched.sv
// Bench for prefix_sched: a timestamp-based transaction model checks every
// output on every cycle; directed scenarios pin key values with literals.
module tb_prefix_sched;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               req_a = 1'b0, req_b = 1'b0;
    logic               opt_a = 1'b0, opt_b = 1'b0;
    logic [4:0]         tok_a = '0, tok_b = '0;
    logic               eng_out_valid = 1'b0;
    logic signed [94:0] eng_out = '0;
    logic               gnt_a, gnt_b;
    logic               eng_in_valid, eng_opt;
    logic [4:0]         eng_in_data;
    logic               res_valid, res_id, res_err;
    logic signed [94:0] res_data;

    always #5 clk = ~clk;

    prefix_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_a        (req_a),
        .req_b        (req_b),
        .gnt_a        (gnt_a),
        .gnt_b        (gnt_b),
        .opt_a        (opt_a),
        .opt_b        (opt_b),
        .tok_a        (tok_a),
        .tok_b        (tok_b),
        .eng_in_valid (eng_in_valid),
        .eng_opt      (eng_opt),
        .eng_in_data  (eng_in_data),
        .eng_out_valid(eng_out_valid),
        .eng_out      (eng_out),
        .res_valid    (res_valid),
        .res_id       (res_id),
        .res_err      (res_err),
        .res_data     (res_data)
    );

    int n_checks = 0;
    int n_err    = 0;
    int k        = 0;

    // Transaction model: one job at a time, described by its grant edge
    bit m_act = 0;
    int m_g = 0;
    bit m_own = 0;
    bit m_prio = 0;
    bit m_opt = 0;
    int m_next = 0;

    int n_ga = 0, n_gb = 0, n_eiv = 0, n_opt = 0, n_ovl = 0;
    int rise_a = 0, rise_b = 0, rise_eiv = 0, fall_k = 0;
    logic p_ga = 0, p_gb = 0, p_eiv = 0;
    logic [4:0]  eiv_q[$];
    logic        res_id_q[$];
    logic        res_err_q[$];
    logic [94:0] res_data_q[$];
    int          res_k_q[$];

    bit          dir_mode = 0, opt_first = 0, spur = 0;
    int          eng_mode = 0;
    logic [94:0] eng_val = '0;
    int          ia = 0, ib = 0, ecd = 0;
    logic        prev_eiv = 0;
    logic [4:0]  seq[19];

    int b_ga, b_gb, b_eiv, b_opt, b_ovl, b_res;

    task automatic chk(input string name, input logic [94:0] got, input logic [94:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, got, exp, k);
        end
    endtask

    task automatic snap();
        b_ga  = n_ga;
        b_gb  = n_gb;
        b_eiv = n_eiv;
        b_opt = n_opt;
        b_ovl = n_ovl;
        b_res = res_id_q.size();
    endtask

    // One clock: model + compare after the edge, then drive inputs at negedge
    task automatic step();
        int          d;
        logic        e_ga, e_gb, e_eiv, e_opt, e_rv, e_rid, e_rerr;
        logic [4:0]  e_data;
        logic [94:0] e_rdata;
        logic [95:0] w;
        @(posedge clk);
        k++;
        e_ga = 0; e_gb = 0; e_eiv = 0; e_opt = 0; e_rv = 0; e_rid = 0; e_rerr = 0;
        e_data = '0; e_rdata = '0;
        if (!rst_n) begin
            m_act = 0; m_prio = 0; m_next = 0;
        end else begin
            if (!m_act && k >= m_next && (req_a || req_b)) begin
                m_own = req_b && (!req_a || m_prio);
                m_act = 1;
                m_g   = k;
            end
            if (m_act) begin
                d = k - m_g;
                if (d == 1) m_opt = m_own ? opt_b : opt_a;
                e_ga = (d <= 18) && !m_own;
                e_gb = (d <= 18) && m_own;
                if (d >= 1 && d <= 19) begin
                    e_eiv  = 1;
                    e_data = m_own ? tok_b : tok_a;
                    e_opt  = m_opt;
                end
                if (d >= 20 && d <= 83 && (eng_out_valid || d == 83)) begin
                    e_rv    = 1;
                    e_rid   = m_own;
                    e_rerr  = !eng_out_valid;
                    e_rdata = eng_out_valid ? eng_out : '0;
                    m_prio  = !m_own;
                    m_next  = k + 2;
                    m_act   = 0;
                end
            end
        end
        #1;
        chk("gnt_a", 95'(gnt_a), 95'(e_ga));
        chk("gnt_b", 95'(gnt_b), 95'(e_gb));
        chk("eng_in_valid", 95'(eng_in_valid), 95'(e_eiv));
        chk("eng_in_data", 95'(eng_in_data), 95'(e_data));
        chk("eng_opt", 95'(eng_opt), 95'(e_opt));
        chk("res_valid", 95'(res_valid), 95'(e_rv));
        chk("res_id", 95'(res_id), 95'(e_rid));
        chk("res_err", 95'(res_err), 95'(e_rerr));
        chk("res_data", 95'(res_data), e_rdata);
        if (gnt_a) n_ga++;
        if (gnt_b) n_gb++;
        if (gnt_a && gnt_b) n_ovl++;
        if (gnt_a && !p_ga) rise_a = k;
        if (gnt_b && !p_gb) rise_b = k;
        if ((p_ga || p_gb) && !(gnt_a || gnt_b)) fall_k = k;
        if (eng_in_valid && !p_eiv) rise_eiv = k;
        if (eng_in_valid) begin
            n_eiv++;
            eiv_q.push_back(eng_in_data);
            if (eng_opt) n_opt++;
        end
        if (res_valid) begin
            res_id_q.push_back(res_id);
            res_err_q.push_back(res_err);
            res_data_q.push_back(res_data);
            res_k_q.push_back(k);
        end
        p_ga = gnt_a; p_gb = gnt_b; p_eiv = eng_in_valid;
        @(negedge clk);
        if (gnt_a) begin
            tok_a = (dir_mode && ia < 19) ? seq[ia] : 5'($urandom);
            opt_a = dir_mode ? ((ia == 0) ? opt_first : !opt_first) : 1'($urandom);
            ia++;
        end else begin
            ia = 0; tok_a = 5'($urandom); opt_a = 1'($urandom);
        end
        if (gnt_b) begin
            tok_b = (dir_mode && ib < 19) ? seq[ib] : 5'($urandom);
            opt_b = dir_mode ? ((ib == 0) ? opt_first : !opt_first) : 1'($urandom);
            ib++;
        end else begin
            ib = 0; tok_b = 5'($urandom); opt_b = 1'($urandom);
        end
        w = {$urandom, $urandom, $urandom};
        eng_out_valid = 1'b0;
        eng_out = '0;
        if (eng_mode == 2) begin
            if ($urandom_range(0, 39) == 0) begin
                eng_out_valid = 1'b1;
                eng_out = w[94:0];
            end
        end else if (eng_mode == 1) begin
            if (ecd > 0) begin
                ecd--;
                if (ecd == 0) begin
                    eng_out_valid = 1'b1;
                    eng_out = eng_val;
                end
            end
            if (prev_eiv && !eng_in_valid) ecd = 3;
        end
        if (spur) begin
            eng_out_valid = 1'b1;
            eng_out = w[94:0];
        end
        prev_eiv = eng_in_valid;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_a = 0; req_b = 0; spur = 0; ecd = 0;
        #1;
        chk("rst_gnt_a", 95'(gnt_a), 95'(0));
        chk("rst_gnt_b", 95'(gnt_b), 95'(0));
        chk("rst_eiv", 95'(eng_in_valid), 95'(0));
        chk("rst_res_valid", 95'(res_valid), 95'(0));
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_res(input int target, input int budget, input string name);
        int i = 0;
        while (res_id_q.size() < target && i < budget) begin
            step();
            i++;
        end
        chk(name, 95'(res_id_q.size()), 95'(target));
    endtask

    task automatic wait_gnt(input string name);
        int i = 0;
        step();
        while (!(gnt_a || gnt_b) && i < 5) begin
            step();
            i++;
        end
        chk(name, 95'(gnt_a || gnt_b), 95'(1));
    endtask

    initial begin
        int i;
        foreach (seq[j]) seq[j] = '0;
        seq[0] = 5'd16; seq[1] = 5'd1; seq[2] = 5'd2;
        #2;
        do_reset();

        // Single A burst with known tokens, engine returns 3
        dir_mode = 1; opt_first = 0; eng_mode = 1; eng_val = 95'd3;
        snap();
        req_a = 1;
        wait_gnt("A_grant");
        req_a = 0;
        wait_res(b_res + 1, 200, "A_res_done");
        chk("A_gnt_cycles", 95'(n_ga - b_ga), 95'(19));
        chk("A_gnt_b_idle", 95'(n_gb - b_gb), 95'(0));
        chk("A_strobes", 95'(n_eiv - b_eiv), 95'(19));
        chk("A_strobe_delay", 95'(rise_eiv - rise_a), 95'(1));
        chk("A_tok0", 95'(eiv_q[b_eiv]), 95'(16));
        chk("A_tok1", 95'(eiv_q[b_eiv + 1]), 95'(1));
        chk("A_tok2", 95'(eiv_q[b_eiv + 2]), 95'(2));
        chk("A_opt", 95'(n_opt - b_opt), 95'(0));
        chk("A_res_id", 95'(res_id_q[b_res]), 95'(0));
        chk("A_res_err", 95'(res_err_q[b_res]), 95'(0));
        chk("A_res_data", res_data_q[b_res], 95'(3));
        step(); step();

        // Both request together: A first, then B after a 2-cycle gap
        do_reset();
        dir_mode = 0; eng_mode = 1; eng_val = 95'h1234;
        snap();
        req_a = 1; req_b = 1;
        wait_res(b_res + 2, 400, "B_res_done");
        req_a = 0; req_b = 0;
        step(); step(); step();
        chk("B_first_id", 95'(res_id_q[b_res]), 95'(0));
        chk("B_second_id", 95'(res_id_q[b_res + 1]), 95'(1));
        chk("B_overlap", 95'(n_ovl - b_ovl), 95'(0));
        chk("B_gap", 95'(rise_b - res_k_q[b_res]), 95'(2));
        chk("B_gnt_a_cycles", 95'(n_ga - b_ga), 95'(19));
        chk("B_gnt_b_cycles", 95'(n_gb - b_gb), 95'(19));

        // Engine silent: timeout result 64 cycles after WAIT entry
        do_reset();
        eng_mode = 0;
        snap();
        req_a = 1;
        wait_gnt("C_grant");
        req_a = 0;
        wait_res(b_res + 1, 300, "C_res_done");
        chk("C_res_err", 95'(res_err_q[b_res]), 95'(1));
        chk("C_res_data", res_data_q[b_res], 95'(0));
        chk("C_timeout_delay", 95'(res_k_q[b_res] - fall_k), 95'(64));
        step(); step();

        // B drops its request mid-burst; opt changes after the first token
        do_reset();
        dir_mode = 1; opt_first = 1; eng_mode = 1; eng_val = 95'd77;
        snap();
        req_b = 1;
        i = 0;
        while ((n_gb - b_gb) < 5 && i < 40) begin
            step();
            i++;
        end
        req_b = 0;
        wait_res(b_res + 1, 200, "D_res_done");
        chk("D_strobes", 95'(n_eiv - b_eiv), 95'(19));
        chk("D_opt_held", 95'(n_opt - b_opt), 95'(19));
        chk("D_gnt_b_cycles", 95'(n_gb - b_gb), 95'(19));
        chk("D_res_id", 95'(res_id_q[b_res]), 95'(1));
        step(); step();

        // Reset in the middle of a burst after the pointer moved to B
        do_reset();
        dir_mode = 0; eng_mode = 1; eng_val = 95'd5;
        snap();
        req_a = 1;
        wait_gnt("E_first_grant");
        req_a = 0;
        wait_res(b_res + 1, 200, "E_first_res");
        step(); step();
        snap();
        req_a = 1;
        i = 0;
        while ((n_ga - b_ga) < 10 && i < 40) begin
            step();
            i++;
        end
        chk("E_reached_tok10", 95'(n_ga - b_ga), 95'(10));
        rst_n = 1'b0;
        #1;
        chk("E_async_gnt_a", 95'(gnt_a), 95'(0));
        chk("E_async_gnt_b", 95'(gnt_b), 95'(0));
        chk("E_async_eiv", 95'(eng_in_valid), 95'(0));
        req_a = 0;
        step(); step();
        rst_n = 1'b1;
        step(); step();
        chk("E_no_partial", 95'(res_id_q.size() - b_res), 95'(0));
        req_a = 1; req_b = 1;
        wait_gnt("E_second_grant");
        chk("E_prio_a", 95'(gnt_a), 95'(1));
        chk("E_prio_not_b", 95'(gnt_b), 95'(0));
        req_a = 0; req_b = 0;
        wait_res(b_res + 1, 200, "E_second_res");
        step(); step();

        // Spurious engine strobes while idle
        do_reset();
        eng_mode = 0;
        snap();
        spur = 1;
        repeat (4) step();
        spur = 0;
        repeat (3) step();
        chk("F_no_res", 95'(res_id_q.size() - b_res), 95'(0));

        // Randomized traffic with random engine behaviour and rare resets
        do_reset();
        dir_mode = 0; eng_mode = 2;
        for (int it = 0; it < 4000; it++) begin
            step();
            if ($urandom_range(0, 9) == 0) req_a = !req_a;
            if ($urandom_range(0, 9) == 0) req_b = !req_b;
            if ($urandom_range(0, 1499) == 0) begin
                rst_n = 1'b0;
                step();
                step();
                rst_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
